// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable data width, parity and stop bits.
// The rx pin is synchronised by two flops. Each bit is decided by a 3-sample majority vote
// around the bit centre. Frame and parity errors are reported as pulses aligned with done.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_clk,
    input  logic                 enabled,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP_0    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP_1    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP_2    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent for the given word.
    function automatic logic par_exp(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic                 stop_idx, stop_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 smp_a, smp_a_n, smp_b, smp_b_n;
    logic                 par_pend, par_pend_n, frm_pend, frm_pend_n;
    logic                 armed, armed_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 done_n, frame_err_n, parity_err_n, busy_n;
    logic                 rx_meta, rx_s;
    logic                 dec, at_dec, wrap;

    // Two-flop synchroniser for the asynchronous pin; idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            smp_a      <= 1'b1;
            smp_b      <= 1'b1;
            par_pend   <= 1'b0;
            frm_pend   <= 1'b0;
            armed      <= 1'b0;
            data       <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            stop_idx   <= stop_n;
            shift_reg  <= shift_n;
            smp_a      <= smp_a_n;
            smp_b      <= smp_b_n;
            par_pend   <= par_pend_n;
            frm_pend   <= frm_pend_n;
            armed      <= armed_n;
            data       <= data_n;
            done       <= done_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
            busy       <= busy_n;
        end
    end

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_n        = bit_idx;
        stop_n       = stop_idx;
        shift_n      = shift_reg;
        smp_a_n      = smp_a;
        smp_b_n      = smp_b;
        par_pend_n   = par_pend;
        frm_pend_n   = frm_pend;
        armed_n      = armed;
        data_n       = data;
        busy_n       = busy;
        done_n       = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
        // Third sample is the live rx_s at the decision tick.
        dec          = maj3(smp_a, smp_b, rx_s);
        at_dec       = (cnt == SMP_2);
        wrap         = (cnt == CNT_LAST);

        if (rx_clk) begin
            cnt_n = cnt + 1'b1;
            if (cnt == SMP_0) smp_a_n = rx_s;
            if (cnt == SMP_1) smp_b_n = rx_s;

            unique case (state)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (rx_s) armed_n = 1'b1;
                    // armed guards against treating a held-low line as a new start bit.
                    if (enabled && armed && !rx_s) begin
                        state_n    = ST_START;
                        armed_n    = 1'b0;
                        busy_n     = 1'b1;
                        par_pend_n = 1'b0;
                        frm_pend_n = 1'b0;
                    end
                end
                ST_START: begin
                    if (at_dec && dec) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        busy_n  = 1'b0;
                    end else if (wrap) begin
                        state_n = ST_DATA;
                        bit_n   = '0;
                    end
                end
                ST_DATA: begin
                    if (at_dec) shift_n = {dec, shift_reg[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_idx == BIT_LAST) begin
                            state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                            stop_n  = 1'b0;
                        end else begin
                            bit_n = bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_dec) par_pend_n = (dec != par_exp(shift_reg));
                    if (wrap) state_n = ST_STOP;
                end
                ST_STOP: begin
                    if (at_dec) begin
                        // Leave on the last stop decision so a following start bit is not missed.
                        if (stop_idx == STOP_LAST) begin
                            state_n      = ST_IDLE;
                            cnt_n        = '0;
                            busy_n       = 1'b0;
                            done_n       = 1'b1;
                            frame_err_n  = frm_pend | ~dec;
                            parity_err_n = par_pend;
                            data_n       = shift_reg;
                        end else begin
                            frm_pend_n = frm_pend | ~dec;
                        end
                    end else if (wrap) begin
                        stop_n = stop_idx + 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule
